// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one completed result per
// cycle from the ALU stations, branch unit and LSQ, registered onto the CDB.
module cdb_arbiter #(
  parameter  int NUM_REQ = 6,
  parameter  int TAG_W   = 4,
  parameter  int DATA_W  = 32,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [SRC_W-1:0]  rr_ptr;
  logic              can_load;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_data;
  int                idx;

  // Load when the output slot is empty or drains this cycle; flush blocks it.
  assign can_load = (~cdb_valid | cdb_ready) & ~flush;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_tag   = '0;
    grant_data  = '0;
    idx         = 0;
    if (can_load && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = SRC_W'(idx);
          grant_tag   = req_tag[idx*TAG_W +: TAG_W];
          grant_data  = req_data[idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (grant_found) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= grant_tag;
      cdb_data  <= grant_data;
      cdb_src   <= grant_idx;
      rr_ptr    <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end else if (flush || cdb_ready) begin
      // Drained or flushed with nothing to refill: payload left as don't-care.
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a round-robin
// reference model, plus directed scenarios for wrap, back-pressure, flush, reset.
module tb_cdb_arbiter;

  localparam int N  = 6;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            flush;
  logic            cdb_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [2:0]      cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .cdb_ready(cdb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  // Requester-side state
  logic          v  [N];
  logic [TW-1:0] tg [N];
  logic [DW-1:0] dt [N];

  // Reference model of the broadcast slot and priority pointer
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // One bus cycle: drive at negedge, check grant, check broadcast after posedge.
  task automatic step(input logic cr, input logic fl, output int g);
    logic [N-1:0] exp_rdy;
    bit can;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_tag[i*TW +: TW]   = tg[i];
      req_data[i*DW +: DW]  = dt[i];
    end
    cdb_ready = cr;
    flush     = fl;
    #1;
    can = (!m_valid || cr) && !fl;
    g = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_rdy = (g < 0) ? '0 : N'(1) << g;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_tag   = tg[g];
      m_data  = dt[g];
      m_src   = g;
      m_ptr   = (g + 1) % N;
    end else if (fl || (m_valid && cr)) begin
      m_valid = 1'b0;
    end
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    if (m_valid) begin
      check("cdb_tag",  64'(cdb_tag),  64'(m_tag));
      check("cdb_data", 64'(cdb_data), 64'(m_data));
      check("cdb_src",  64'(cdb_src),  64'(m_src));
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(cdb_valid), 64'(0));
    check("rst_ready",       64'(req_ready), 64'(0));
    model_reset();
    @(negedge clk);
    check("rst_tag",  64'(cdb_tag),  64'(0));
    check("rst_data", 64'(cdb_data), 64'(0));
    check("rst_src",  64'(cdb_src),  64'(0));
    req_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    flush     = 1'b0;
    cdb_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; tg[i] = '0; dt[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(cdb_valid), 64'(0));
    check("reset_tag",   64'(cdb_tag),   64'(0));
    check("reset_data",  64'(cdb_data),  64'(0));
    check("reset_src",   64'(cdb_src),   64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU0 result
    v[0] = 1'b1; tg[0] = 4'h3; dt[0] = 32'hDEADBEEF;
    step(1'b1, 1'b0, g);
    check("t1_valid", 64'(cdb_valid), 64'(1));
    check("t1_tag",   64'(cdb_tag),   64'(4'h3));
    check("t1_data",  64'(cdb_data),  64'(32'hDEADBEEF));
    check("t1_src",   64'(cdb_src),   64'(0));
    clear_reqs();

    // Reset while a broadcast is pending, then full rotation from index 0
    mid_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; tg[i] = TW'(i + 8); dt[i] = 32'h1000_0000 + 32'(i);
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, g);
      check("t2_order", 64'(cdb_src),   64'(k % N));
      check("t2_valid", 64'(cdb_valid), 64'(1));
      tg[k % N] = TW'($urandom);
      dt[k % N] = $urandom;
    end

    // Back-pressure with only the LSQ requesting
    clear_reqs();
    v[5] = 1'b1; tg[5] = 4'hA; dt[5] = 32'hCAFE_0005;
    repeat (3) step(1'b0, 1'b0, g);
    step(1'b1, 1'b0, g);
    check("t3_src",  64'(cdb_src),  64'(5));
    check("t3_data", 64'(cdb_data), 64'(32'hCAFE_0005));
    clear_reqs();
    step(1'b1, 1'b0, g);
    check("t3_drain", 64'(cdb_valid), 64'(0));

    // Move pointer to 4, then wrap past 4 and 5
    v[3] = 1'b1;
    step(1'b1, 1'b0, g);
    clear_reqs();
    v[0] = 1'b1; v[2] = 1'b1;
    step(1'b1, 1'b0, g);
    check("t4_wrap0", 64'(cdb_src), 64'(0));
    v[0] = 1'b0;
    step(1'b1, 1'b0, g);
    check("t4_then2", 64'(cdb_src), 64'(2));
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    step(1'b1, 1'b0, g);
    check("t4_ptr3", 64'(cdb_src), 64'(3));

    // Flush with a valid broadcast and the branch unit requesting
    clear_reqs();
    v[4] = 1'b1; tg[4] = 4'h7; dt[4] = 32'h0BAD_F00D;
    step(1'b1, 1'b1, g);
    check("t5_flush_valid", 64'(cdb_valid), 64'(0));
    step(1'b1, 1'b0, g);
    check("t5_resume_src",   64'(cdb_src),   64'(4));
    check("t5_resume_valid", 64'(cdb_valid), 64'(1));

    // Reset restarts priority at index 0
    clear_reqs();
    v[2] = 1'b1; v[3] = 1'b1;
    mid_reset();
    step(1'b1, 1'b0, g);
    check("t6_first_src", 64'(cdb_src), 64'(2));

    // Randomized traffic honouring the hold-until-ready rule
    for (int c = 0; c < 400; c++) begin
      logic cr, fl;
      cr = ($urandom % 4) != 0;
      fl = ($urandom % 16) == 0;
      step(cr, fl, g);
      for (int i = 0; i < N; i++) begin
        if (g == i || fl || !v[i]) begin
          v[i]  = ($urandom % 2) != 0;
          tg[i] = TW'($urandom);
          dt[i] = $urandom;
        end
      end
      if (c == 200) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
